// File: rtl/pwm_pkg.sv
// Shared constants and duty clamp helper for the PWM pulse generator.
package pwm_pkg;

  localparam int CNT_W_DEF  = 6;
  localparam int DUTY_W_DEF = 7;
  localparam int DUTY_FULL  = 64;

  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned full);
    return (duty > full) ? full : duty;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Single-channel rising-edge delay: output rises only after the request has been high
// for DEAD_CYCLES consecutive cycles; falls immediately with the request.
module pwm_deadtime #(
  parameter int DEAD_CYCLES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic out
);

  localparam int HW = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);
  localparam logic [HW-1:0] DEAD_L = HW'(DEAD_CYCLES);

  logic [HW-1:0] hist_r;
  logic          out_r;

  // Count consecutive high requests (saturating) and gate the registered output on it
  always_ff @(posedge sysclk) begin
    if (reset) begin
      hist_r <= {HW{1'b0}};
      out_r  <= 1'b0;
    end else if (!enable) begin
      hist_r <= {HW{1'b0}};
      out_r  <= 1'b0;
    end else begin
      out_r <= raw && (hist_r == DEAD_L);
      if (!raw) begin
        hist_r <= {HW{1'b0}};
      end else if (hist_r == DEAD_L) begin
        hist_r <= hist_r;
      end else begin
        hist_r <= hist_r + HW'(1);
      end
    end
  end

  assign out = out_r;

endmodule

// File: rtl/pwm_pulse_gen.sv
// Fixed-period PWM generator with period-boundary duty double-buffering.
// Optional dead-time insertion on both outputs when PWM_DEADTIME_EN is defined.
module pwm_pulse_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int DEAD_CYCLES = 2
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              pwm_out,
  output logic              pwm_out_n,
  output logic              period_start,
  output logic [DUTY_W-1:0] duty_active
);

  localparam int unsigned    FULL_L  = 32'd1 << CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  cnt_r;
  logic [DUTY_W-1:0] shadow_r;
  logic [DUTY_W-1:0] dclamp_s;
  logic              pwm_nxt_s;
  logic              pwm_n_nxt_s;
  logic              period_start_r;

  // Clamp request and form the per-cycle compare result
  always_comb begin
    dclamp_s    = DUTY_W'(clamp_duty(32'(duty_in), FULL_L));
    pwm_nxt_s   = enable && (DUTY_W'(cnt_r) < shadow_r);
    pwm_n_nxt_s = enable && !pwm_nxt_s;
  end

  // Period counter and shadow duty; disabled state parks at the last count
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_r    <= CNT_MAX;
      shadow_r <= {DUTY_W{1'b0}};
    end else if (!enable) begin
      cnt_r    <= CNT_MAX;
      shadow_r <= dclamp_s;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (cnt_r == CNT_MAX) begin
        shadow_r <= dclamp_s;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  // Period strobe aligned with the first output cycle of each period
  always_ff @(posedge sysclk) begin
    if (reset) begin
      period_start_r <= 1'b0;
    end else begin
      period_start_r <= enable && (cnt_r == {CNT_W{1'b0}});
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(.DEAD_CYCLES(DEAD_CYCLES)) u_dt_p (
    .sysclk (sysclk),
    .reset  (reset),
    .enable (enable),
    .raw    (pwm_nxt_s),
    .out    (pwm_out)
  );

  pwm_deadtime #(.DEAD_CYCLES(DEAD_CYCLES)) u_dt_n (
    .sysclk (sysclk),
    .reset  (reset),
    .enable (enable),
    .raw    (pwm_n_nxt_s),
    .out    (pwm_out_n)
  );
`else
  logic pwm_r;
  logic pwm_n_r;

  // Registered complementary outputs, both low while disabled
  always_ff @(posedge sysclk) begin
    if (reset) begin
      pwm_r   <= 1'b0;
      pwm_n_r <= 1'b0;
    end else begin
      pwm_r   <= pwm_nxt_s;
      pwm_n_r <= pwm_n_nxt_s;
    end
  end

  assign pwm_out   = pwm_r;
  assign pwm_out_n = pwm_n_r;
`endif

  assign period_start = period_start_r;
  assign duty_active  = shadow_r;

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// Directed self-checking bench for pwm_pulse_gen (64-count periods, 7-bit duty).
module tb_pwm_pulse_gen;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] duty_in;
  logic       pwm_out;
  logic       pwm_out_n;
  logic       period_start;
  logic [6:0] duty_active;

  int vectors = 0;
  int miscompares = 0;

  pwm_pulse_gen dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .enable       (enable),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .pwm_out_n    (pwm_out_n),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_ps(input int exp_steps, input string tag);
    int n = 0;
    while (period_start !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    vectors++;
    if (n !== exp_steps) begin
      miscompares++;
      $display("FAIL %s wait_ps: got %0d steps, expected %0d", tag, n, exp_steps);
    end
  endtask

  // Walk one full period from a period_start sample; optionally change duty_in at sample chg_at
  task automatic check_period(input int exp_hi, input int chg_at, input logic [6:0] chg_val,
                              input string tag);
    int hi = 0;
    int bad = 0;
    int bad_n = 0;
    int bad_ps = 0;
    logic e;
    for (int i = 0; i < 64; i++) begin
      if (i == chg_at) duty_in = chg_val;
      e = (i < exp_hi);
      if (pwm_out !== e) bad++;
      if (pwm_out_n !== !e) bad_n++;
      if (period_start !== (i == 0)) bad_ps++;
      if (pwm_out === 1'b1) hi++;
      step();
    end
    vectors++;
    if (hi !== exp_hi) begin
      miscompares++;
      $display("FAIL %s high_count: got %0d, expected %0d", tag, hi, exp_hi);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s pwm_shape: %0d wrong cycles, expected 0", tag, bad);
    end
    vectors++;
    if (bad_n !== 0) begin
      miscompares++;
      $display("FAIL %s pwm_n_shape: %0d wrong cycles, expected 0", tag, bad_n);
    end
    vectors++;
    if (bad_ps !== 0) begin
      miscompares++;
      $display("FAIL %s period_start_shape: %0d wrong cycles, expected 0", tag, bad_ps);
    end
    vectors++;
    if (period_start !== 1'b1) begin
      miscompares++;
      $display("FAIL %s next_boundary: period_start=%b, expected 1", tag, period_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; duty_in = 7'd0;
    repeat (3) step();
    vectors++;
    if (pwm_out !== 1'b0) begin miscompares++; $display("FAIL reset pwm_out: got %b, expected 0", pwm_out); end
    vectors++;
    if (pwm_out_n !== 1'b0) begin miscompares++; $display("FAIL reset pwm_out_n: got %b, expected 0", pwm_out_n); end
    vectors++;
    if (period_start !== 1'b0) begin miscompares++; $display("FAIL reset period_start: got %b, expected 0", period_start); end
    vectors++;
    if (duty_active !== 7'd0) begin miscompares++; $display("FAIL reset duty_active: got %0d, expected 0", duty_active); end
  endtask

  task automatic test_duty16();
    reset = 1'b0; enable = 1'b1; duty_in = 7'd16;
    step();
    vectors++;
    if (duty_active !== 7'd16) begin miscompares++; $display("FAIL d16 duty_active: got %0d, expected 16", duty_active); end
    vectors++;
    if (pwm_out !== 1'b0 || pwm_out_n !== 1'b1) begin
      miscompares++;
      $display("FAIL d16 pre_period: got pwm=%b n=%b, expected pwm=0 n=1", pwm_out, pwm_out_n);
    end
    wait_ps(1, "d16");
    check_period(16, -1, 7'd0, "d16_p1");
    check_period(16, -1, 7'd0, "d16_p2");
  endtask

  task automatic test_duty_0_64();
    check_period(16, 0, 7'd0, "d0_pre");
    check_period(0, 0, 7'd64, "d0");
    check_period(64, -1, 7'd0, "d64_p1");
    check_period(64, -1, 7'd0, "d64_p2");
    vectors++;
    if (duty_active !== 7'd64) begin miscompares++; $display("FAIL d64 duty_active: got %0d, expected 64", duty_active); end
  endtask

  task automatic test_clamp();
    check_period(64, 0, 7'd100, "clamp_pre");
    vectors++;
    if (duty_active !== 7'd64) begin miscompares++; $display("FAIL clamp duty_active: got %0d, expected 64", duty_active); end
    check_period(64, -1, 7'd0, "clamp");
  endtask

  task automatic test_mid_change();
    check_period(64, 0, 7'd16, "mid_pre");
    vectors++;
    if (duty_active !== 7'd16) begin miscompares++; $display("FAIL mid duty_active_old: got %0d, expected 16", duty_active); end
    check_period(16, 20, 7'd48, "mid_cur");
    vectors++;
    if (duty_active !== 7'd48) begin miscompares++; $display("FAIL mid duty_active_new: got %0d, expected 48", duty_active); end
    check_period(48, -1, 7'd0, "mid_next");
  endtask

  task automatic test_enable_drop();
    check_period(48, 0, 7'd32, "en_pre");
    vectors++;
    if (duty_active !== 7'd32) begin miscompares++; $display("FAIL en duty_active: got %0d, expected 32", duty_active); end
    repeat (10) step();
    vectors++;
    if (pwm_out !== 1'b1) begin miscompares++; $display("FAIL en pwm_before_drop: got %b, expected 1", pwm_out); end
    enable = 1'b0;
    step();
    vectors++;
    if (pwm_out !== 1'b0 || pwm_out_n !== 1'b0 || period_start !== 1'b0) begin
      miscompares++;
      $display("FAIL en drop_outputs: got pwm=%b n=%b ps=%b, expected 0 0 0", pwm_out, pwm_out_n, period_start);
    end
    duty_in = 7'd8;
    step();
    vectors++;
    if (duty_active !== 7'd8) begin miscompares++; $display("FAIL en disabled_load: got %0d, expected 8", duty_active); end
    repeat (3) step();
    vectors++;
    if (pwm_out !== 1'b0 || pwm_out_n !== 1'b0) begin
      miscompares++;
      $display("FAIL en idle: got pwm=%b n=%b, expected 0 0", pwm_out, pwm_out_n);
    end
    enable = 1'b1;
    step();
    vectors++;
    if (pwm_out !== 1'b0 || pwm_out_n !== 1'b1 || period_start !== 1'b0) begin
      miscompares++;
      $display("FAIL en reenable_first: got pwm=%b n=%b ps=%b, expected 0 1 0", pwm_out, pwm_out_n, period_start);
    end
    wait_ps(1, "en");
    check_period(8, -1, 7'd0, "en_d8");
  endtask

  // Count high cycles of each output and overlaps over one period window
  task automatic dt_window(input int exp_p, input int exp_n, input int chg_at,
                           input logic [6:0] chg_val, input string tag);
    int hp = 0;
    int hn = 0;
    int ov = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == chg_at) duty_in = chg_val;
      if (pwm_out === 1'b1) hp++;
      if (pwm_out_n === 1'b1) hn++;
      if (pwm_out === 1'b1 && pwm_out_n === 1'b1) ov++;
      step();
    end
    vectors++;
    if (hp !== exp_p) begin miscompares++; $display("FAIL %s dt_pwm_high: got %0d, expected %0d", tag, hp, exp_p); end
    vectors++;
    if (hn !== exp_n) begin miscompares++; $display("FAIL %s dt_pwm_n_high: got %0d, expected %0d", tag, hn, exp_n); end
    vectors++;
    if (ov !== 0) begin miscompares++; $display("FAIL %s dt_overlap: got %0d, expected 0", tag, ov); end
  endtask

  task automatic test_deadtime();
    reset = 1'b0; enable = 1'b1; duty_in = 7'd16;
    step();
    wait_ps(1, "dt");
    dt_window(14, 46, -1, 7'd0, "dt16_p1");
    dt_window(14, 46, 0, 7'd2, "dt16_p2");
    dt_window(0, 60, -1, 7'd0, "dt2");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; duty_in = 7'd0;
    test_reset();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`else
    test_duty16();
    test_duty_0_64();
    test_clamp();
    test_mid_change();
    test_enable_drop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
